// File: rtl/hilf6_vq_sel.sv
// Element selector for the 6-element ISI-shaping DEM path: ranks the loop-filter
// states and turns on the K lowest-ranked elements, with a rotating tie-break.
module hilf6_vq_sel #(
  parameter int N  = 6,
  parameter int W  = 4,
  parameter int KW = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic [KW-1:0] K,
  input  logic [W-1:0]  SFI5,
  input  logic [W-1:0]  SFI4,
  input  logic [W-1:0]  SFI3,
  input  logic [W-1:0]  SFI2,
  input  logic [W-1:0]  SFI1,
  input  logic [W-1:0]  SFI0,
  output logic [N-1:0]  SV,
  output logic [N-1:0]  ST,
  output logic          ovf
);

  // en is a sample strobe with no backpressure: every clock edge with en=1
  // consumes K and SFI and produces a new SV/ST one cycle later.

  logic [2:0]    ptr;
  logic [W-1:0]  sfi  [N];
  logic [2:0]    ord  [N];
  logic [2:0]    rank [N];
  logic [KW-1:0] ks;
  logic [N-1:0]  sv_next;
  logic          k_over;

  assign sfi[0] = SFI0;
  assign sfi[1] = SFI1;
  assign sfi[2] = SFI2;
  assign sfi[3] = SFI3;
  assign sfi[4] = SFI4;
  assign sfi[5] = SFI5;

  assign k_over = (K > KW'(N));
  assign ks     = k_over ? KW'(N) : K;

  // Tie-break order: the element at ptr wins ties, then ptr+1, and so on.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      ord[i] = '0;
      if (3'(i) >= ptr) ord[i] = 3'(i) - ptr;
      else              ord[i] = 3'(i) + 3'(N) - ptr;
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      rank[i] = '0;
      for (int j = 0; j < N; j++) begin
        if ((j != i) &&
            ((sfi[j] < sfi[i]) || ((sfi[j] == sfi[i]) && (ord[j] < ord[i]))))
          rank[i] = rank[i] + 3'd1;
      end
    end
  end

  always_comb begin
    sv_next = '0;
    for (int i = 0; i < N; i++)
      sv_next[i] = (rank[i] < ks);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      SV  <= '0;
      ST  <= '0;
      ovf <= 1'b0;
      ptr <= '0;
    end else if (en) begin
      SV  <= sv_next;
      ST  <= sv_next & ~SV;
      ptr <= (ptr == 3'(N - 1)) ? 3'd0 : ptr + 3'd1;
      if (k_over) ovf <= 1'b1;
    end else begin
      ST <= '0;
    end
  end

endmodule

// File: tb/tb_hilf6_vq_sel.sv
// Directed bench for hilf6_vq_sel: a table of hand-computed vectors applied
// back to back from reset, plus reset and mid-stream reset sequences.
module tb_hilf6_vq_sel;

  logic        clk;
  logic        rstn;
  logic        en;
  logic [2:0]  k;
  logic [23:0] sfi_bus;
  logic [5:0]  sv;
  logic [5:0]  st;
  logic        ovf;

  int tests;
  int fails;

  typedef struct {
    logic        en;
    logic [2:0]  k;
    logic [23:0] sfi;
    logic [5:0]  exp_sv;
    logic [5:0]  exp_st;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [17];

  hilf6_vq_sel dut (
    .clk  (clk),
    .rstn (rstn),
    .en   (en),
    .K    (k),
    .SFI5 (sfi_bus[23:20]),
    .SFI4 (sfi_bus[19:16]),
    .SFI3 (sfi_bus[15:12]),
    .SFI2 (sfi_bus[11:8]),
    .SFI1 (sfi_bus[7:4]),
    .SFI0 (sfi_bus[3:0]),
    .SV   (sv),
    .ST   (st),
    .ovf  (ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic e, logic [2:0] kk, logic [23:0] s,
                              logic [5:0] esv, logic [5:0] est, logic eovf);
    vec_t v;
    v.en = e; v.k = kk; v.sfi = s;
    v.exp_sv = esv; v.exp_st = est; v.exp_ovf = eovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " sv"}, sv, 6'b0);
    chk({tag, " st"}, st, 6'b0);
    chk({tag, " ovf"}, {5'b0, ovf}, 6'b0);
  endtask

  // driver: present inputs after the falling edge, sample 1 unit after the rising edge
  task automatic drive_step(input logic e, input logic [2:0] kk, input logic [23:0] s);
    @(negedge clk);
    en = e; k = kk; sfi_bus = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0; fails = 0;
    rstn = 1'b0; en = 1'b0; k = '0; sfi_bus = '0;

    // Walk from reset: ptr 0,1,2,(hold),3,4,5,0,(hold),1,2,3,4,5,0,(hold),1
    vecs[0]  = mk(1, 3'd2, 24'h000000, 6'b000011, 6'b000011, 0);
    vecs[1]  = mk(1, 3'd2, 24'h000000, 6'b000110, 6'b000100, 0);
    vecs[2]  = mk(1, 3'd2, 24'h000000, 6'b001100, 6'b001000, 0);
    vecs[3]  = mk(0, 3'd5, 24'h123456, 6'b001100, 6'b000000, 0);
    vecs[4]  = mk(1, 3'd2, 24'h000000, 6'b011000, 6'b010000, 0);
    vecs[5]  = mk(1, 3'd2, 24'h000000, 6'b110000, 6'b100000, 0);
    vecs[6]  = mk(1, 3'd2, 24'h000000, 6'b100001, 6'b000001, 0);
    vecs[7]  = mk(1, 3'd3, 24'h317025, 6'b010110, 6'b010110, 0);
    vecs[8]  = mk(0, 3'd6, 24'h000000, 6'b010110, 6'b000000, 0);
    vecs[9]  = mk(1, 3'd0, 24'h317025, 6'b000000, 6'b000000, 0);
    vecs[10] = mk(1, 3'd6, 24'h317025, 6'b111111, 6'b111111, 0);
    vecs[11] = mk(1, 3'd3, 24'h252920, 6'b101001, 6'b000000, 0);
    vecs[12] = mk(1, 3'd4, 24'h252920, 6'b101011, 6'b000010, 0);
    vecs[13] = mk(1, 3'd7, 24'h252920, 6'b111111, 6'b010100, 1);
    vecs[14] = mk(1, 3'd1, 24'h000000, 6'b000001, 6'b000000, 1);
    vecs[15] = mk(0, 3'd7, 24'h000000, 6'b000001, 6'b000000, 1);
    vecs[16] = mk(1, 3'd2, 24'hFFFFFE, 6'b000011, 6'b000010, 1);

    // Reset held low: outputs clear
    #2;
    chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Released with en=0 for three cycles: outputs stay clear
    for (int c = 0; c < 3; c++) begin
      drive_step(1'b0, 3'd3, 24'h000000);
      chk_zero($sformatf("idle%0d", c));
    end

    // Table-driven vectors
    for (int i = 0; i < 17; i++) begin
      drive_step(vecs[i].en, vecs[i].k, vecs[i].sfi);
      chk($sformatf("v%0d sv", i), sv, vecs[i].exp_sv);
      chk($sformatf("v%0d st", i), st, vecs[i].exp_st);
      chk($sformatf("v%0d ovf", i), {5'b0, ovf}, {5'b0, vecs[i].exp_ovf});
    end

    // Mid-stream reset: ovf is set and the rotation is running
    drive_step(1'b1, 3'd2, 24'h000000);
    chk("pre-reset ovf", {5'b0, ovf}, 6'b000001);
    #2;
    rstn = 1'b0;
    #1;
    chk_zero("async reset");
    en = 1'b0;
    #2;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("post-release idle");

    // Rotation restarts from ptr=0 with an empty SV history
    drive_step(1'b1, 3'd2, 24'h000000);
    chk("restart1 sv", sv, 6'b000011);
    chk("restart1 st", st, 6'b000011);
    drive_step(1'b1, 3'd2, 24'h000000);
    chk("restart2 sv", sv, 6'b000110);
    chk("restart2 st", st, 6'b000100);
    chk("restart2 ovf", {5'b0, ovf}, 6'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
